id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Single-entry ID/EX pipeline register that sits directly upstream of the ALU and drives its data1, data2 and alu_control inputs.
- Accepts decoded instruction fields and register-file read values over a valid/ready handshake.
- Decodes the ALU operation, selects register or immediate operand B, and holds the entry until the execute stage accepts it.
- Supports flush for branch redirect and, optionally, operand forwarding from writeback.

Parameters:
- XLEN, 32, datapath width of operands and result.
- REG_AW, 5, register index width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_opcode  input  7  instruction opcode field.
- in_funct3  input  3  funct3 field.
- in_funct7b5  input  1  bit 30 of the instruction.
- in_rs1, in_rs2  input  REG_AW  source register indices.
- in_rd  input  REG_AW  destination register index.
- in_rs1_val, in_rs2_val  input  XLEN  register-file read data.
- in_imm  input  XLEN  sign-extended I-type immediate.
- flush  input  1  discard held and incoming instruction.
- wb_valid  input  1  writeback is committing this cycle.
- wb_rd  input  REG_AW  writeback destination index.
- wb_data  input  XLEN  writeback value.
- out_valid  output  1  entry valid toward execute.
- out_ready  input  1  execute accepts the entry.
- data1  output  XLEN  ALU operand A.
- data2  output  XLEN  ALU operand B.
- alu_control  output  4  ALU operation code.
- out_rd  output  REG_AW  destination index carried forward.
- out_illegal  output  1  instruction not executable by the ALU.

Behaviour:
- Reset (asynchronous, takes effect immediately): out_valid=0, data1=0, data2=0, alu_control=4'b0000, out_rd=0, out_illegal=0. The stored rs1/rs2 indices and the immediate-select flag also reset to 0.
- in_ready = !out_valid || out_ready (combinational). Capture occurs when in_valid && in_ready && !flush.
- Latency is one cycle: fields captured at edge N appear on the outputs after edge N.
- After a capture, out_valid=1. If there is no capture and out_valid && out_ready, out_valid=0. While out_valid && !out_ready, every output holds stable.
- flush has priority over everything except reset: on the next edge out_valid=0 and no capture occurs. The data outputs may keep stale values.
- alu_control decode for opcode 7'b0110011 (R-type):
  - funct3 000: 0110 (SUB) if funct7b5=1, else 0010 (ADD).
  - funct3 100: 0011 (XOR).
  - funct3 110: 0001 (OR).
  - funct3 111: 0000 (AND).
- alu_control decode for opcode 7'b0010011 (I-type): same mapping, except funct3 000 is always 0010, because funct7b5 is ignored for ADDI.
- Any other opcode or funct3: alu_control=4'b1111 and out_illegal=1. The ALU produces 0 for this code; the entry still flows through the handshake normally.
- Operand select: data1 = rs1 value. data2 = in_imm for I-type, otherwise the rs2 value.
- All arithmetic is width-preserving; there is no extension or truncation in this stage.
- Simultaneous capture and drain (out_valid && out_ready && in_valid): the new entry replaces the old one in the same edge, with no bubble.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined, forwarding at capture: if wb_valid && wb_rd!=0 && wb_rd==in_rs1, data1 takes wb_data. rs2 is handled likewise, but data2 takes wb_data only when the entry is not I-type.
- Defined, forwarding while held: while out_valid && !out_ready, a matching writeback to the stored rs1/rs2 overwrites data1/data2, subject to the same x0 and I-type rules.
- Defined, priority: forwarded wb_data beats the register-file value.
- Undefined: wb_* inputs are ignored, no rs indices are stored, and operands come solely from the in_* values.

Test Plan:
- R-type SUB decode: opcode 0110011, funct3 000, funct7b5=1, rs1_val=10, rs2_val=3, out_ready=1 -> one cycle later out_valid=1, alu_control=0110, data1=10, data2=3, out_illegal=0.
- ADDI operand select: opcode 0010011, funct3 000, funct7b5=1, imm=0xFFFFFFFF, rs2_val=7 -> alu_control=0010, data2=0xFFFFFFFF.
- Back-pressure: capture XOR, hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable for those cycles. Then raise out_ready=1 -> the new entry replaces the XOR entry in the same edge.
- Flush and async reset: flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0. Separately, assert rst mid-cycle -> out_valid=0 and alu_control=0000 immediately, before the next clock edge.
- Illegal opcode: opcode 0000011 -> alu_control=1111, out_illegal=1, out_valid=1.
- Forwarding (with ID_EX_FWD_EN defined):
  - wb_valid=1, wb_rd=5=in_rs1, wb_data=0xAA at capture -> data1=0xAA.
  - wb_rd=0 -> no forwarding.
  - Held entry with stored rs2=6, R-type: wb to register 6 with wb_data=0x55 -> data2 becomes 0x55.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: decodes alu_control, selects operand B, holds under back-pressure.
// Optional writeback forwarding (capture-time and while held) is enabled by defining ID_EX_FWD_EN.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [XLEN-1:0]   in_rs2_val,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   data1,
    output logic [XLEN-1:0]   data2,
    output logic [3:0]        alu_control,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_illegal
);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    // Returns {illegal, alu_control}; unsupported opcode/funct3 maps to 1111.
    function automatic logic [4:0] f_decode(input logic [6:0] op, input logic [2:0] f3,
                                            input logic f7b5);
        logic [3:0] ctrl;
        logic       ill;
        ctrl = 4'b1111;
        ill  = 1'b1;
        if (op == OP_R || op == OP_I) begin
            ill = 1'b0;
            case (f3)
                3'b000:  ctrl = (op == OP_R && f7b5) ? 4'b0110 : 4'b0010;
                3'b100:  ctrl = 4'b0011;
                3'b110:  ctrl = 4'b0001;
                3'b111:  ctrl = 4'b0000;
                default: begin
                    ctrl = 4'b1111;
                    ill  = 1'b1;
                end
            endcase
        end
        return {ill, ctrl};
    endfunction

    logic              r_valid;
    logic [XLEN-1:0]   r_data1;
    logic [XLEN-1:0]   r_data2;
    logic [3:0]        r_ctrl;
    logic [REG_AW-1:0] r_rd;
    logic              r_illegal;

    logic              w_capture;
    logic              w_is_itype;
    logic [4:0]        w_dec;
    logic [XLEN-1:0]   w_op_a;
    logic [XLEN-1:0]   w_op_b;

    assign in_ready   = !r_valid || out_ready;
    assign w_capture  = in_valid && in_ready && !flush;
    assign w_is_itype = (in_opcode == OP_I);
    assign w_dec      = f_decode(in_opcode, in_funct3, in_funct7b5);

`ifdef ID_EX_FWD_EN
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic              r_is_itype;
    logic              w_wb_live;
    logic              w_hold_fwd1;
    logic              w_hold_fwd2;

    assign w_wb_live   = wb_valid && (wb_rd != '0);
    assign w_op_a      = (w_wb_live && wb_rd == in_rs1) ? wb_data : in_rs1_val;
    assign w_op_b      = w_is_itype ? in_imm :
                         ((w_wb_live && wb_rd == in_rs2) ? wb_data : in_rs2_val);
    assign w_hold_fwd1 = w_wb_live && (wb_rd == r_rs1);
    assign w_hold_fwd2 = w_wb_live && (wb_rd == r_rs2) && !r_is_itype;
`else
    logic w_unused_fwd;

    // Writeback and source indices only matter when forwarding is built in.
    assign w_unused_fwd = &{1'b0, wb_valid, wb_rd, wb_data, in_rs1, in_rs2};
    assign w_op_a       = in_rs1_val;
    assign w_op_b       = w_is_itype ? in_imm : in_rs2_val;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_data1    <= '0;
            r_data2    <= '0;
            r_ctrl     <= 4'b0000;
            r_rd       <= '0;
            r_illegal  <= 1'b0;
`ifdef ID_EX_FWD_EN
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_is_itype <= 1'b0;
`endif
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid    <= 1'b1;
            r_data1    <= w_op_a;
            r_data2    <= w_op_b;
            r_ctrl     <= w_dec[3:0];
            r_illegal  <= w_dec[4];
            r_rd       <= in_rd;
`ifdef ID_EX_FWD_EN
            r_rs1      <= in_rs1;
            r_rs2      <= in_rs2;
            r_is_itype <= w_is_itype;
`endif
        end else begin
            if (out_ready) begin
                r_valid <= 1'b0;
`ifdef ID_EX_FWD_EN
            end else if (r_valid) begin
                // Held entry keeps picking up late writebacks to its sources.
                if (w_hold_fwd1) r_data1 <= wb_data;
                if (w_hold_fwd2) r_data2 <= wb_data;
`endif
            end
        end
    end

    assign out_valid   = r_valid;
    assign data1       = r_data1;
    assign data2       = r_data2;
    assign alu_control = r_ctrl;
    assign out_rd      = r_rd;
    assign out_illegal = r_illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed literal checks plus randomized traffic against a behavioural model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_ready, in_funct7b5 = 1'b0;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0, wb_rd = '0, out_rd;
    logic [31:0] in_rs1_val = '0, in_rs2_val = '0, in_imm = '0, wb_data = '0;
    logic        flush = 1'b0, wb_valid = 1'b0, out_valid, out_ready = 1'b0, out_illegal;
    logic [31:0] data1, data2;
    logic [3:0]  alu_control;

    int n_vec = 0;
    int n_err = 0;

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .data1(data1), .data2(data2),
        .alu_control(alu_control), .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // ALU code from the instruction table; 1111 means not executable.
    function automatic logic [3:0] m_code(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bit r, i;
        r = (op == 7'b0110011);
        i = (op == 7'b0010011);
        if (!(r || i)) return 4'hF;
        if (f3 == 3'd0) return (r && f7) ? 4'h6 : 4'h2;
        if (f3 == 3'd4) return 4'h3;
        if (f3 == 3'd6) return 4'h1;
        if (f3 == 3'd7) return 4'h0;
        return 4'hF;
    endfunction

    function automatic bit m_hit(input logic [4:0] rs);
`ifdef ID_EX_FWD_EN
        return wb_valid && wb_rd != 5'd0 && wb_rd == rs;
`else
        return (rs != rs); // forwarding absent: never matches
`endif
    endfunction

    logic        m_valid, m_isi;
    logic [31:0] m_d1, m_d2;
    logic [3:0]  m_ctrl;
    logic [4:0]  m_rd, m_rs1, m_rs2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0; m_d1 <= '0; m_d2 <= '0; m_ctrl <= '0; m_rd <= '0;
            m_rs1 <= '0; m_rs2 <= '0; m_isi <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid <= 1'b1;
            m_ctrl  <= m_code(in_opcode, in_funct3, in_funct7b5);
            m_rd    <= in_rd;
            m_rs1   <= in_rs1;
            m_rs2   <= in_rs2;
            m_isi   <= (in_opcode == 7'b0010011);
            m_d1    <= m_hit(in_rs1) ? wb_data : in_rs1_val;
            m_d2    <= (in_opcode == 7'b0010011) ? in_imm : (m_hit(in_rs2) ? wb_data : in_rs2_val);
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end else if (m_valid) begin
            if (m_hit(m_rs1)) m_d1 <= wb_data;
            if (m_hit(m_rs2) && !m_isi) m_d2 <= wb_data;
        end
    end

    always @(negedge clk) begin
        chk("m_in_ready", {31'd0, in_ready}, {31'd0, !m_valid || out_ready});
        chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("m_data1", data1, m_d1);
            chk("m_data2", data2, m_d2);
            chk("m_alu_control", {28'd0, alu_control}, {28'd0, m_ctrl});
            chk("m_out_rd", {27'd0, out_rd}, {27'd0, m_rd});
            chk("m_out_illegal", {31'd0, out_illegal}, {31'd0, m_ctrl == 4'hF});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        in_valid = v; in_opcode = op; in_funct3 = f3; in_funct7b5 = f7;
        in_rs1 = r1; in_rs2 = r2; in_rd = rd;
        in_rs1_val = a; in_rs2_val = b; in_imm = imm;
    endtask

    localparam logic [6:0] R = 7'b0110011;
    localparam logic [6:0] I = 7'b0010011;

    initial begin
        logic [31:0] rv;
        #1 rst = 1'b1;
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data1", data1, 32'd0);
        chk("rst_data2", data2, 32'd0);
        chk("rst_alu_control", {28'd0, alu_control}, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
        rst = 1'b0;

        // SUB
        out_ready = 1'b1;
        drv(1, R, 3'b000, 1, 5'd1, 5'd2, 5'd7, 32'd10, 32'd3, 32'd99);
        tick();
        chk("sub_valid", {31'd0, out_valid}, 32'd1);
        chk("sub_alu", {28'd0, alu_control}, 32'h6);
        chk("sub_data1", data1, 32'd10);
        chk("sub_data2", data2, 32'd3);
        chk("sub_illegal", {31'd0, out_illegal}, 32'd0);

        // ADDI ignores funct7b5 and selects the immediate
        drv(1, I, 3'b000, 1, 5'd1, 5'd2, 5'd8, 32'd4, 32'd7, 32'hFFFF_FFFF);
        tick();
        chk("addi_alu", {28'd0, alu_control}, 32'h2);
        chk("addi_data2", data2, 32'hFFFF_FFFF);

        // Back-pressure on an XOR entry
        drv(1, R, 3'b100, 0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd9, 32'd0);
        tick();
        chk("xor_alu", {28'd0, alu_control}, 32'h3);
        out_ready = 1'b0;
        drv(1, R, 3'b111, 0, 5'd1, 5'd2, 5'd4, 32'd1, 32'd2, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_alu", {28'd0, alu_control}, 32'h3);
            chk("bp_rd", {27'd0, out_rd}, 32'd3);
            chk("bp_data1", data1, 32'd5);
        end
        out_ready = 1'b1;
        tick();
        chk("replace_valid", {31'd0, out_valid}, 32'd1);
        chk("replace_alu", {28'd0, alu_control}, 32'h0);
        chk("replace_rd", {27'd0, out_rd}, 32'd4);

        // Flush beats both the held and the incoming entry
        out_ready = 1'b0;
        flush = 1'b1;
        drv(1, R, 3'b110, 0, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2, 32'd0);
        tick();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;
        out_ready = 1'b1;

        // Illegal opcode and illegal funct3
        drv(1, 7'b0000011, 3'b010, 0, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 32'd3);
        tick();
        chk("illop_alu", {28'd0, alu_control}, 32'hF);
        chk("illop_illegal", {31'd0, out_illegal}, 32'd1);
        chk("illop_valid", {31'd0, out_valid}, 32'd1);
        drv(1, R, 3'b001, 0, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 32'd3);
        tick();
        chk("illf3_alu", {28'd0, alu_control}, 32'hF);
        chk("illf3_illegal", {31'd0, out_illegal}, 32'd1);

        // Asynchronous reset mid-cycle
        drv(0, R, 3'b000, 0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_alu", {28'd0, alu_control}, 32'd0);
        tick();
        rst = 1'b0;

        // Writeback forwarding at capture
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hAA;
        drv(1, R, 3'b000, 0, 5'd5, 5'd2, 5'd1, 32'd1, 32'd2, 32'd0);
        tick();
`ifdef ID_EX_FWD_EN
        chk("fwd_cap_data1", data1, 32'hAA);
`else
        chk("nofwd_cap_data1", data1, 32'h1);
`endif
        wb_rd = 5'd0; wb_data = 32'h77;
        drv(1, R, 3'b000, 0, 5'd0, 5'd2, 5'd1, 32'd7, 32'd2, 32'd0);
        tick();
        chk("fwd_x0_data1", data1, 32'd7);

        // Writeback forwarding into a held entry
        wb_valid = 1'b0;
        drv(1, R, 3'b110, 0, 5'd1, 5'd6, 5'd2, 32'd2, 32'd2, 32'd0);
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h55;
        tick();
`ifdef ID_EX_FWD_EN
        chk("fwd_hold_data2", data2, 32'h55);
`else
        chk("nofwd_hold_data2", data2, 32'h2);
`endif
        chk("fwd_hold_data1", data1, 32'h2);
        wb_valid = 1'b0; out_ready = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rv = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0, 1:    in_opcode = R;
                2:       in_opcode = I;
                default: in_opcode = rv[6:0];
            endcase
            in_funct3   = rv[9:7];
            in_funct7b5 = rv[10];
            in_rs1      = 5'($urandom_range(0, 7));
            in_rs2      = 5'($urandom_range(0, 7));
            in_rd       = 5'($urandom);
            in_rs1_val  = $urandom;
            in_rs2_val  = $urandom;
            in_imm      = $urandom;
            wb_valid    = rv[11];
            wb_rd       = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
